radix_lane_mult: RTL and testbench

- Parametrised successor to the team's single-bit, two-lane shift-add multiplier. Used for the wide products in the RSA/modexp datapath.
- Multiplier operand is split into LANES independent slices. Each lane consumes DIGIT_BITS multiplier bits per cycle, so latency drops by roughly LANES*DIGIT_BITS.
- Both operands are captured at start. Fixed, predictable latency; result held until the next job; optional early termination.

---
 rtl/radix_lane_mult.sv | 153 +++++++++++++++
 tb/tb_radix_lane_mult.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/radix_lane_mult.sv
// radix_lane_mult: multi-lane, multi-digit shift-add multiplier.
//
// The multiplier operand is split into LANES slices of SLICE bits. Every MULT cycle each lane
// consumes DIGIT_BITS bits of its slice and adds the matching shifted partial product into its
// own accumulator. On the finish edge the accumulators are summed into the registered result.
// Latency is STEPS+1 edges after acceptance. When the EARLY_EXIT_EN macro is defined, the job
// also finishes as soon as every lane slice has been shifted down to zero.
//
// Ports:
//   clk_in     sole clock, rising edge
//   rst_in     synchronous, active-high reset
//   ready_in   start request, sampled only while idle
//   input_1    multiplicand (unsigned, INPUT_SIZE bits)
//   input_2    multiplier   (unsigned, INPUT_SIZE bits)
//   result     registered product, held until the next job finishes
//   busy_out   high while a job is in progress
//   valid_out  one-cycle pulse when result updates
//
// Optional feature macro: EARLY_EXIT_EN

module radix_lane_mult #(
    parameter int unsigned INPUT_SIZE  = 1024,
    parameter int unsigned LANES       = 4,
    parameter int unsigned DIGIT_BITS  = 2,
    parameter int unsigned OUTPUT_SIZE = 2 * INPUT_SIZE
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   ready_in,
    input  logic [INPUT_SIZE-1:0]  input_1,
    input  logic [INPUT_SIZE-1:0]  input_2,
    output logic [OUTPUT_SIZE-1:0] result,
    output logic                   busy_out,
    output logic                   valid_out
);

    localparam int unsigned SLICE  = INPUT_SIZE / LANES;
    localparam int unsigned STEPS  = SLICE / DIGIT_BITS;
    localparam int unsigned STEP_W = $clog2(STEPS + 1);

    typedef enum logic [0:0] {StIdle, StMult} state_e;

    state_e                 state_q, state_d;
    logic [INPUT_SIZE-1:0]  mcand_q, mcand_d;
    logic [SLICE-1:0]       slice_q [LANES];
    logic [SLICE-1:0]       slice_d [LANES];
    logic [OUTPUT_SIZE-1:0] acc_q   [LANES];
    logic [OUTPUT_SIZE-1:0] acc_d   [LANES];
    logic [STEP_W-1:0]      step_q, step_d;
    logic [OUTPUT_SIZE-1:0] result_q, result_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    logic [OUTPUT_SIZE-1:0] acc_sum;
    logic [OUTPUT_SIZE-1:0] pp;
    int unsigned            shamt;
    logic                   finish;

    // One-cycle adder tree over the lane accumulators.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            acc_sum = acc_sum + acc_q[k];
        end
    end

`ifdef EARLY_EXIT_EN
    // Once every slice is zero the remaining steps would only add zero partial products.
    logic all_zero;
    always_comb begin
        all_zero = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (slice_q[k] != '0) all_zero = 1'b0;
        end
        finish = (step_q == STEP_W'(STEPS)) || all_zero;
    end
`else
    assign finish = (step_q == STEP_W'(STEPS));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        slice_d  = slice_q;
        acc_d    = acc_q;
        step_d   = step_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        pp       = '0;
        shamt    = 0;

        unique case (state_q)
            StIdle: begin
                if (ready_in) begin
                    mcand_d = input_1;
                    for (int k = 0; k < LANES; k++) begin
                        slice_d[k] = input_2[k*SLICE +: SLICE];
                        acc_d[k]   = '0;
                    end
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = StMult;
                end
            end
            StMult: begin
                if (finish) begin
                    result_d = acc_sum;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end else begin
                    for (int k = 0; k < LANES; k++) begin
                        pp = OUTPUT_SIZE'(mcand_q) * OUTPUT_SIZE'(slice_q[k][DIGIT_BITS-1:0]);
                        // Lane k's slice starts at bit k*SLICE; each step advances one digit.
                        shamt      = 32'(k) * SLICE + 32'(step_q) * DIGIT_BITS;
                        acc_d[k]   = acc_q[k] + (pp << shamt);
                        slice_d[k] = slice_q[k] >> DIGIT_BITS;
                    end
                    step_d = step_q + STEP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            slice_q  <= '{default: '0};
            acc_q    <= '{default: '0};
            step_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            slice_q  <= slice_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign busy_out  = busy_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_radix_lane_mult.sv
// Self-checking bench for radix_lane_mult with INPUT_SIZE=16, LANES=2, DIGIT_BITS=2 (STEPS=4).
// Latency expectations follow the EARLY_EXIT_EN setting of the build.

module tb_radix_lane_mult;

    localparam int N         = 16;
    localparam int FIXED_LAT = 5;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            ready_in;
    logic [N-1:0]    input_1;
    logic [N-1:0]    input_2;
    logic [2*N-1:0]  result;
    logic            busy_out;
    logic            valid_out;

    int n_total = 0;
    int n_pass  = 0;

    radix_lane_mult #(
        .INPUT_SIZE (N),
        .LANES      (2),
        .DIGIT_BITS (2)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .ready_in  (ready_in),
        .input_1   (input_1),
        .input_2   (input_2),
        .result    (result),
        .busy_out  (busy_out),
        .valid_out (valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] prod;
        int             lat_early;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int exp_lat(input int lat_early);
`ifdef EARLY_EXIT_EN
        return lat_early;
`else
        return FIXED_LAT + 0 * lat_early;
`endif
    endfunction

    // Presents operands with ready_in high for exactly one edge (E0).
    task automatic start(input logic [N-1:0] a, input logic [N-1:0] b);
        input_1  = a;
        input_2  = b;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    // Counts edges after E0 until valid_out; -1 on timeout. busy_ok drops if busy ever falls early.
    task automatic wait_valid(output int lat, output bit busy_ok);
        busy_ok = busy_out;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (valid_out) return;
            if (!busy_out) busy_ok = 1'b0;
        end
        lat = -1;
    endtask

    initial begin
        int  lat;
        int  gap;
        bit  busy_ok;
        bit  seen;
        bit  stable;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 5};
        vecs[1]  = '{16'h0000, 16'h1234, 32'h00000000, 4};
        vecs[2]  = '{16'h1234, 16'h0000, 32'h00000000, 1};
        vecs[3]  = '{16'h1234, 16'h0003, 32'h0000369C, 2};
        vecs[4]  = '{16'h00FF, 16'h0101, 32'h0000FFFF, 2};
        vecs[5]  = '{16'h8000, 16'h0002, 32'h00010000, 2};
        vecs[6]  = '{16'h0002, 16'h0003, 32'h00000006, 2};
        vecs[7]  = '{16'h00FF, 16'hFF00, 32'h00FE0100, 5};
        vecs[8]  = '{16'hABCD, 16'h1000, 32'h0ABCD000, 4};
        vecs[9]  = '{16'h1234, 16'h5678, 32'h06260060, 5};
        vecs[10] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 2};

        rst_in   = 1'b1;
        ready_in = 1'b0;
        input_1  = '0;
        input_2  = '0;
        tick();
        tick();
        check("reset_busy",   64'(busy_out),  64'd0);
        check("reset_valid",  64'(valid_out), 64'd0);
        check("reset_result", 64'(result),    64'd0);
        rst_in = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            start(vecs[i].a, vecs[i].b);
            wait_valid(lat, busy_ok);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].lat_early)));
            check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].prod));
            check($sformatf("vec%0d_busy_during", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_busy_at_valid", i), 64'(busy_out), 64'd0);
            tick();
            check($sformatf("vec%0d_valid_drop", i), 64'(valid_out), 64'd0);
            check($sformatf("vec%0d_result_hold", i), 64'(result), 64'(vecs[i].prod));
        end

        // Operand changes after acceptance must not disturb the running job.
        start(16'h1234, 16'h0003);
        input_1 = 16'hAAAA;
        input_2 = 16'hAAAA;
        wait_valid(lat, busy_ok);
        check("capture_latency", 64'(lat), 64'(exp_lat(2)));
        check("capture_result", 64'(result), 64'h369C);
        tick();

        // Reset two edges into a job aborts it without a valid pulse.
        start(16'hFFFF, 16'hFFFF);
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("abort_busy",   64'(busy_out),  64'd0);
        check("abort_valid",  64'(valid_out), 64'd0);
        check("abort_result", 64'(result),    64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_out || busy_out) seen = 1'b1;
        end
        check("abort_no_pulse", 64'(seen), 64'd0);
        start(16'h0002, 16'h0003);
        wait_valid(lat, busy_ok);
        check("after_abort_latency", 64'(lat), 64'(exp_lat(2)));
        check("after_abort_result", 64'(result), 64'h6);
        tick();

        // ready_in held high: back-to-back jobs, one per STEPS+2 cycles.
        input_1  = 16'h00FF;
        input_2  = 16'h0101;
        ready_in = 1'b1;
        tick();
        input_1 = 16'h8000;
        input_2 = 16'h0002;
        wait_valid(lat, busy_ok);
        check("b2b_first_latency", 64'(lat), 64'(exp_lat(2)));
        check("b2b_first_result", 64'(result), 64'hFFFF);
        check("b2b_first_busy", 64'(busy_ok), 64'd1);
        gap    = 0;
        stable = 1'b1;
        while (gap < 20) begin
            tick();
            gap++;
            if (gap == 1) ready_in = 1'b0;
            if (valid_out) break;
            if (result !== 32'h0000FFFF) stable = 1'b0;
        end
        check("b2b_gap", 64'(gap), 64'(exp_lat(2) + 1));
        check("b2b_stable", 64'(stable), 64'd1);
        check("b2b_second_result", 64'(result), 64'h10000);
        tick();
        check("b2b_idle_after", 64'(busy_out), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
